// File: rtl/arb_out_fifo.sv
// arb_out_fifo: first-word-fall-through FIFO placed after the 2:1 round-robin
// arbiter so the arbiter can keep granting while the consumer stalls.
// Pointers carry one extra wrap bit to tell full from empty without a counter.
// Optional build macro ARB_FIFO_LEVEL_EN adds the level / almost_full outputs
// and the registered occupancy count behind them.
module arb_out_fifo #(
    parameter int DWIDTH    = 20,
    parameter int DEPTH     = 4,
    parameter int AFULL_THR = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DWIDTH-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DWIDTH-1:0]          out_data,
    input  logic                       out_ready
`ifdef ARB_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;

    // Status and handshakes depend on pointer state only, never on the
    // opposite side's inputs, so there is no combinational path through.
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        in_ready  = !full;
        out_valid = !empty;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    // Pointer update; increments wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; entries are only visible once written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_data;
    end

`ifdef ARB_FIFO_LEVEL_EN
    localparam logic [PW-1:0] AFULL_C = PW'(AFULL_THR);

    logic [PW-1:0] count;

    // Registered occupancy; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Expose occupancy and the threshold compare.
    always_comb begin
        level       = count;
        almost_full = (count >= AFULL_C);
    end
`endif

endmodule

// File: tb/tb_arb_out_fifo.sv
// Directed bench for arb_out_fifo (DWIDTH=20, DEPTH=4). Inputs change 1ns after
// the rising edge; outputs are checked at that same point, away from the edge.
module tb_arb_out_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [19:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [19:0] out_data;
    logic        out_ready;
`ifdef ARB_FIFO_LEVEL_EN
    logic [2:0]  level;
    logic        almost_full;
`endif

    int n_cmp = 0;
    int n_err = 0;

    arb_out_fifo #(.DWIDTH(20), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef ARB_FIFO_LEVEL_EN
        , .level(level), .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (out_data !== 20'h0) begin n_err++; $display("FAIL reset_out_data got %h exp 00000", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
`ifdef ARB_FIFO_LEVEL_EN
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", level); end
        n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b exp 0", almost_full); end
`endif
    endtask

    task automatic test_single_word();
        // no same-cycle bypass: still empty while the push is being presented
        in_valid = 1'b1; in_data = 20'h0A5A5; out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_no_bypass got %b exp 0", out_valid); end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 20'h0A5A5) begin
                n_err++; $display("FAIL single_hold[%0d] got v=%b d=%h exp v=1 d=0a5a5", i, out_valid, out_data); end
            if (i < 3) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || out_data !== 20'h0) begin
            n_err++; $display("FAIL single_popped got v=%b d=%h exp v=0 d=00000", out_valid, out_data); end
    endtask

    task automatic test_fill_full();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d] got %b exp 1", i, in_ready); end
            in_valid = 1'b1; in_data = 20'(i);
            tick();
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        in_data = 20'h5;
        tick();
        n_cmp++; if (in_ready !== 1'b0 || out_data !== 20'h1) begin
            n_err++; $display("FAIL full_held got rdy=%b d=%h exp rdy=0 d=00001", in_ready, out_data); end
`ifdef ARB_FIFO_LEVEL_EN
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL full_level got %0d exp 4", level); end
        n_cmp++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL full_afull got %b exp 1", almost_full); end
`endif
    endtask

    task automatic test_full_pop();
        logic [19:0] exp_q [4];
        exp_q = '{20'h2, 20'h3, 20'h4, 20'h5};
        // at full with both sides active: only the pop happens
        in_valid = 1'b1; in_data = 20'h5; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || out_data !== 20'h2) begin
            n_err++; $display("FAIL fullpop_after got rdy=%b d=%h exp rdy=1 d=00002", in_ready, out_data); end
`ifdef ARB_FIFO_LEVEL_EN
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL fullpop_level got %0d exp 3", level); end
`endif
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
                n_err++; $display("FAIL fullpop_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_q[i]); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_streaming_wrap();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 20'(i);
            if (i > 0) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== 20'(i - 1)) begin
                    n_err++; $display("FAIL stream[%0d] got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, 20'(i - 1)); end
`ifdef ARB_FIFO_LEVEL_EN
                n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL stream_level[%0d] got %0d exp 1", i, level); end
`endif
            end
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (out_data !== 20'h13) begin n_err++; $display("FAIL stream_last got %h exp 00013", out_data); end
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 20'h00A0 + 20'(i);
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (out_data !== 20'h000A0) begin n_err++; $display("FAIL mid_pre got %h exp 000a0", out_data); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 20'h0) begin
            n_err++; $display("FAIL mid_reset got v=%b rdy=%b d=%h exp v=0 rdy=1 d=00000", out_valid, in_ready, out_data); end
`ifdef ARB_FIFO_LEVEL_EN
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL mid_level got %0d exp 0", level); end
`endif
        in_valid = 1'b1; in_data = 20'hFFFFF;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 20'hFFFFF) begin
            n_err++; $display("FAIL mid_first got v=%b d=%h exp v=1 d=fffff", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_drain got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_full();
        test_full_pop();
        test_streaming_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arb_out_fifo.md
Name: arb_out_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO that sits directly downstream of the 2:1 round-robin arbiter.
- Absorbs back-pressure from the consumer so the arbiter can keep granting while the sink stalls.
- Valid/ready handshake on both sides; the input side connects 1:1 to the arbiter's out_valid/out_data/out_ready.

Parameters:
- DWIDTH, 20, payload width in bits; must match the arbiter.
- DEPTH, 4, number of entries; power of two, >= 2.
- AFULL_THR, DEPTH-1, occupancy at or above which almost_full asserts (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  upstream data valid.
- in_data  input  DWIDTH  upstream payload.
- in_ready  output  1  FIFO can accept this cycle.
- out_valid  output  1  head entry valid.
- out_data  output  DWIDTH  head entry payload.
- out_ready  input  1  downstream accepts this cycle.
- level  output  $clog2(DEPTH)+1  occupancy count; present only with ARB_FIFO_LEVEL_EN.
- almost_full  output  1  level >= AFULL_THR; present only with ARB_FIFO_LEVEL_EN.

Behaviour:
- Single clock domain; all state updates on posedge clk.
- Reset: rst_n sampled low at a clock edge clears the following:
  - write pointer, read pointer and count to 0;
  - memory contents are don't-care.
  - After that edge: out_valid=0, out_data=0, in_ready=1, level=0, almost_full=0.
- Pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (index bits equal) && (MSBs differ).
- Handshakes:
  - push = in_valid && in_ready; pop = out_valid && out_ready.
  - in_ready = !full; it is combinational from state only and never depends on in_valid or out_ready.
  - out_valid = !empty; it is combinational from state only.
  - out_data = mem[rd_ptr index] when !empty, else all zeros.
- Latency: a word pushed into an empty FIFO at edge N appears on out_valid/out_data in the cycle after edge N (1-cycle latency). There is no same-cycle bypass.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged across cycles.
- Push only: write mem[wr idx] <= in_data, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop in the same cycle (0 < count < DEPTH): both pointers advance and count is unchanged.
- Full: in_ready=0, so no push occurs even if out_ready=1 that cycle. The freed slot becomes writable in the next cycle.
- Empty: out_valid=0 and no pop occurs; out_ready is ignored.
- Wrap-around: pointers increment modulo 2*DEPTH; index bits wrap modulo DEPTH.
- Reset mid-operation: contents are flushed; any in-flight word is lost. No output glitches beyond the defined reset values.
- Order: strict FIFO; no reordering, no duplication, no drop.

Optional Feature:
- Macro: ARB_FIFO_LEVEL_EN.
- Defined:
  - level and almost_full ports exist.
  - level equals the registered count (0..DEPTH) and updates the cycle after each push/pop.
  - almost_full = (count >= AFULL_THR), combinational from count.
- Undefined: the ports and the compare logic are absent; FIFO behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> out_valid=0, out_data=0, in_ready=1, level=0.
- Single word: push 20'h0A5A5 into empty FIFO with out_ready=0 -> next cycle out_valid=1, out_data=20'h0A5A5. Data holds for 3 stalled cycles, then pops on out_ready=1, and out_valid=0 the cycle after.
- Fill to full: DEPTH=4, push 20'h1..20'h4 with out_ready=0 -> in_ready=0 after the 4th push. A 5th word 20'h5 held on in_valid is not accepted. level=4, almost_full=1.
- Full with simultaneous out_ready: at full, assert in_valid=1 and out_ready=1 -> 20'h1 pops, 20'h5 is not written that cycle. in_ready=1 next cycle; 20'h5 is accepted and emerges after 20'h2..20'h4.
- Streaming wrap: in_valid=out_ready=1 for 20 cycles with incrementing data 20'h0..20'h13 -> output sequence identical and in order. count steady at 1 after the first cycle; pointers wrap at least twice.
- Reset mid-stream: with 3 entries held, drive rst_n=0 for one edge -> next cycle out_valid=0, in_ready=1, level=0. A new push of 20'hFFFFF emerges as the first output.
